chacha20_keystream_xor_serializer: RTL and testbench

- Downstream neighbour of the 20-round (10 double-round) block function.
- Takes the post-rounds 512-bit state and the original input state, and performs the final per-word feed-forward addition into a 16-word keystream register.
- Streams 32-bit data words through an XOR with the keystream, one word per handshake, through a registered output stage.
- Signals upstream when a fresh block (next counter value) is needed.

---
 rtl/chacha20_pkg.sv | 32 +++
 rtl/chacha20_state_feed_forward.sv | 22 ++
 rtl/chacha20_keystream_xor_serializer.sv | 98 +++++++++
 tb/tb_chacha20_keystream_xor_serializer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chacha20_pkg
// Description : Shared ChaCha20 constants, state-word slicing helper, FSM enum
// Revision    : 1.0
// ============================================================================
package chacha20_pkg;

    localparam int STATE_WORDS = 16;
    localparam int WORD_BITS   = 32;
    localparam int STATE_BITS  = STATE_WORDS * WORD_BITS;

    // "expand 32-byte k" sigma words occupying state words 0..3
    localparam logic [WORD_BITS-1:0] CHACHA_CONST_0 = 32'h61707865;
    localparam logic [WORD_BITS-1:0] CHACHA_CONST_1 = 32'h3320646e;
    localparam logic [WORD_BITS-1:0] CHACHA_CONST_2 = 32'h79622d32;
    localparam logic [WORD_BITS-1:0] CHACHA_CONST_3 = 32'h6b206574;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic logic [WORD_BITS-1:0] state_word(
        input logic [STATE_BITS-1:0] state,
        input int unsigned           index
    );
        return state[index*WORD_BITS +: WORD_BITS];
    endfunction

endpackage
`default_nettype wire

// File: rtl/chacha20_state_feed_forward.sv
`default_nettype none
// ============================================================================
// Module      : chacha20_state_feed_forward
// Description : Wordwise mod-2^32 addition of initial and mixed ChaCha20 state
// Revision    : 1.0
// ============================================================================
module chacha20_state_feed_forward
    import chacha20_pkg::*;
(
    input  logic [STATE_BITS-1:0] initial_state,
    input  logic [STATE_BITS-1:0] mixed_state,
    output logic [STATE_BITS-1:0] sum_state
);

    // Separate 32-bit adders so no carry propagates into the neighbouring word
    for (genvar i = 0; i < STATE_WORDS; i++) begin : g_word
        assign sum_state[i*WORD_BITS +: WORD_BITS] =
            state_word(initial_state, i) + state_word(mixed_state, i);
    end

endmodule
`default_nettype wire

// File: rtl/chacha20_keystream_xor_serializer.sv
`default_nettype none
// ============================================================================
// Module      : chacha20_keystream_xor_serializer
// Description : Feed-forward keystream register and XOR word streamer
// Revision    : 1.0
// ============================================================================
module chacha20_keystream_xor_serializer
    import chacha20_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  block_in_valid,
    output logic                  block_in_ready,
    input  logic [STATE_BITS-1:0] initial_state,
    input  logic [STATE_BITS-1:0] mixed_state,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_last,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_last,
    output logic                  block_done
);

    localparam logic [3:0] LAST_INDEX = 4'(WORDS_PER_BLOCK - 1);

    state_t                r_state;
    logic [3:0]            r_word_index;
    logic [WORD_BITS-1:0]  r_keystream [STATE_WORDS];
    logic [STATE_BITS-1:0] w_block_sum;
    logic                  w_accept;
    logic                  w_block_end;

    chacha20_state_feed_forward u_feed_forward (
        .initial_state (initial_state),
        .mixed_state   (mixed_state),
        .sum_state     (w_block_sum)
    );

    assign block_in_ready = (r_state == IDLE);
    // One-entry output register: accept whenever it is empty or draining now
    assign data_in_ready  = (r_state == STREAM) && (!data_out_valid || data_out_ready);
    assign w_accept       = data_in_valid && data_in_ready;
    assign w_block_end    = w_accept && (data_in_last || (r_word_index == LAST_INDEX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_word_index   <= '0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            data_out_last  <= 1'b0;
            block_done     <= 1'b0;
            for (int i = 0; i < STATE_WORDS; i++) begin
                r_keystream[i] <= '0;
            end
        end else begin
            block_done <= w_block_end;

            case (r_state)
                IDLE: begin
                    if (block_in_valid) begin
                        for (int i = 0; i < STATE_WORDS; i++) begin
                            r_keystream[i] <= state_word(w_block_sum, i);
                        end
                        r_word_index <= '0;
                        r_state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        r_word_index <= r_word_index + 4'd1;
                        if (w_block_end) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Output stage drains independently of the block state
            if (w_accept) begin
                data_out       <= data_in ^ r_keystream[r_word_index];
                data_out_last  <= data_in_last;
                data_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chacha20_keystream_xor_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_chacha20_keystream_xor_serializer
// Description : Directed + randomized self-checking bench with keystream model
// Revision    : 1.0
// ============================================================================
module tb_chacha20_keystream_xor_serializer;

    logic         clock = 1'b0;
    logic         reset;
    logic         block_in_valid;
    logic         block_in_ready;
    logic [511:0] initial_state;
    logic [511:0] mixed_state;
    logic         data_in_valid;
    logic         data_in_ready;
    logic [31:0]  data_in;
    logic         data_in_last;
    logic         data_out_valid;
    logic         data_out_ready;
    logic [31:0]  data_out;
    logic         data_out_last;
    logic         block_done;

    chacha20_keystream_xor_serializer #(
        .DATA_WIDTH      (32),
        .WORDS_PER_BLOCK (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .block_in_valid (block_in_valid),
        .block_in_ready (block_in_ready),
        .initial_state  (initial_state),
        .mixed_state    (mixed_state),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_in        (data_in),
        .data_in_last   (data_in_last),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .data_out       (data_out),
        .data_out_last  (data_out_last),
        .block_done     (block_done)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [32:0] got [$];
    logic [32:0] exp_q [$];
    logic [31:0] ks [16];
    int          midx = 0;
    logic        rand_ready = 1'b0;

    logic [31:0] rfc_init [16] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    logic [31:0] rfc_ks [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    always @(posedge clock) cyc++;

    // Output handshakes and done pulses are observed mid-cycle
    always @(negedge clock) begin
        if (!reset && data_out_valid && data_out_ready) got.push_back({data_out_last, data_out});
        if (!reset && block_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic load_block(input logic [511:0] init_s, input logic [511:0] mix_s);
        logic acc;
        int   n;
        initial_state  = init_s;
        mixed_state    = mix_s;
        block_in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clock); acc = block_in_ready;
            @(posedge clock); #1; n++;
        end while (!acc && n < 200);
        block_in_valid = 1'b0;
        if (!acc) check("block_accept_timeout", 0, 1);
        for (int i = 0; i < 16; i++) ks[i] = init_s[32*i +: 32] + mix_s[32*i +: 32];
        midx = 0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        logic acc;
        int   n;
        data_in       = d;
        data_in_last  = last;
        data_in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clock); acc = data_in_ready;
            @(posedge clock); #1; n++;
            if (rand_ready) data_out_ready = 1'($urandom_range(0, 1));
        end while (!acc && n < 200);
        data_in_valid = 1'b0;
        if (!acc) begin
            check("send_timeout", 0, 1);
        end else begin
            exp_q.push_back({last, d ^ ks[midx]});
            midx++;
            if (last || midx == 16) exp_done++;
        end
    endtask

    task automatic settle();
        rand_ready     = 1'b0;
        data_out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic compare(input string tag);
        int n;
        check($sformatf("%s_count", tag), 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        check($sformatf("%s_done", tag), 64'(done_cnt), 64'(exp_done));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [511:0] init_s, mix_s, rfc_i, rfc_m;
        int           start, snap, len;

        reset = 1'b1; block_in_valid = 0; initial_state = '0; mixed_state = '0;
        data_in_valid = 0; data_in = '0; data_in_last = 0; data_out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(data_out_valid), 0);
        check("rst_out_data", 64'(data_out), 0);
        check("rst_out_last", 64'(data_out_last), 0);
        check("rst_block_done", 64'(block_done), 0);
        check("rst_block_in_ready", 64'(block_in_ready), 1);
        check("rst_data_in_ready", 64'(data_in_ready), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rfc_i[32*i +: 32] = rfc_init[i];
            rfc_m[32*i +: 32] = rfc_ks[i] - rfc_init[i];
        end

        // RFC 8439 block, all-zero plaintext exposes the keystream
        load_block(rfc_i, rfc_m);
        for (int i = 0; i < 16; i++) send(32'h0, 1'b0);
        settle();
        check("rfc_word0", 64'(got[0]), 64'({1'b0, 32'he4e7f110}));
        check("rfc_word15", 64'(got[15]), 64'({1'b0, 32'h4e3c50a2}));
        check("rfc_block_in_ready", 64'(block_in_ready), 1);
        compare("rfc");

        // XOR invertibility with the same block
        load_block(rfc_i, rfc_m);
        send(32'hffffffff, 1'b1);
        settle();
        check("inv_fwd", 64'(got[0]), 64'({1'b1, 32'h1b180eef}));
        compare("inv_fwd_q");
        load_block(rfc_i, rfc_m);
        send(32'h1b180eef, 1'b1);
        settle();
        check("inv_back", 64'(got[0][31:0]), 64'(32'hffffffff));
        compare("inv_back_q");

        // Early last on word 3, then a fresh block restarts at index 0
        load_block(rand512(), rand512());
        for (int i = 0; i < 4; i++) send($urandom, i == 3);
        settle();
        check("early_last_idle", 64'(block_in_ready), 1);
        check("early_last_din_rdy", 64'(data_in_ready), 0);
        compare("early_last");
        load_block(rand512(), rand512());
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) send($urandom, 1'b0);
        settle();
        compare("restart");

        // Backpressure for 5 cycles, then full throughput
        load_block(rand512(), rand512());
        data_out_ready = 1'b0;
        send(32'h11111111, 1'b0);
        data_in = 32'h22222222; data_in_last = 1'b0; data_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("bp_din_rdy_c%0d", c), 64'(data_in_ready), 0);
            check($sformatf("bp_hold_c%0d", c), 64'({data_out_valid, data_out}), 64'({1'b1, exp_q[0][31:0]}));
            @(posedge clock); #1;
        end
        data_out_ready = 1'b1;
        start = cyc;
        send(32'h22222222, 1'b0);
        for (int i = 2; i < 16; i++) send($urandom, 1'b0);
        check("bp_throughput_cycles", 64'(cyc - start), 15);
        settle();
        compare("bp");

        // Carry isolation between adjacent words
        init_s = rand512(); mix_s = rand512();
        init_s[31:0] = 32'hffffffff; mix_s[31:0] = 32'h00000001;
        load_block(init_s, mix_s);
        send(32'h0, 1'b0);
        send(32'h0, 1'b1);
        settle();
        check("carry_word0", 64'(got[0][31:0]), 0);
        check("carry_word1", 64'(got[1][31:0]), 64'(32'(init_s[63:32] + mix_s[63:32])));
        compare("carry");

        // Asynchronous reset with word 7 pending
        load_block(rand512(), rand512());
        for (int i = 0; i < 7; i++) send($urandom, 1'b0);
        snap = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("mrst_out_valid", 64'(data_out_valid), 0);
        check("mrst_out_data", 64'(data_out), 0);
        check("mrst_out_last", 64'(data_out_last), 0);
        check("mrst_block_in_ready", 64'(block_in_ready), 1);
        @(posedge clock); #1;
        check("mrst_block_done", 64'(block_done), 0);
        reset = 1'b0;
        void'(exp_q.pop_back());
        check("mrst_no_done", 64'(done_cnt), 64'(snap));
        compare("mrst");
        load_block(rand512(), rand512());
        for (int i = 0; i < 16; i++) send($urandom, 1'b0);
        settle();
        compare("post_rst");

        // Random lengths with random downstream stalls
        for (int b = 0; b < 4; b++) begin
            load_block(rand512(), rand512());
            rand_ready = 1'b1;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) send($urandom, i == len - 1);
            settle();
            compare($sformatf("rand%0d", b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
